// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the conv_3x3 frame sequencer.
package conv_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_W = 3'd1,
      ST_CLR    = 3'd2,
      ST_STREAM = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_FIN    = 3'd5
   } ctrl_state_t;

   localparam int N_TAPS = 9;
   localparam logic [3:0] LAST_TAP = 4'd8;

   // Weight memory address: kernel index above a 4-bit tap field.
   function automatic logic [31:0] tap_addr(input logic [31:0] kern, input logic [3:0] tap);
      return (kern * 32'd16) + {28'd0, tap};
   endfunction

   function automatic logic cfg_legal(input logic [15:0] w, input logic [15:0] h, input int nk,
                                      input int max_w, input int max_h, input int max_k);
      return (int'(w) >= 32'sd3) && (int'(w) <= max_w) &&
             (int'(h) >= 32'sd3) && (int'(h) <= max_h) &&
             (nk >= 32'sd1) && (nk <= max_k);
   endfunction

endpackage

// File: rtl/conv_kernel_bank.sv
// Nine-tap weight register file feeding the engine's packed kernel input.
module conv_kernel_bank
   import conv_ctrl_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [3:0]               idx,
   input  logic [DATA_W-1:0]        wdata,
   output logic [N_TAPS*DATA_W-1:0] kern
);

   logic [DATA_W-1:0] tap_q [N_TAPS];
   logic [DATA_W-1:0] tap_d [N_TAPS];

   always_comb begin
      for (int i = 0; i < N_TAPS; i++) begin
         if (we && (idx == 4'(i))) begin
            tap_d[i] = wdata;
         end else begin
            tap_d[i] = tap_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_TAPS; i++) tap_q[i] <= '0;
      end else begin
         for (int i = 0; i < N_TAPS; i++) tap_q[i] <= tap_d[i];
      end
   end

   always_comb begin
      kern = '0;
      for (int i = 0; i < N_TAPS; i++) kern[i*DATA_W +: DATA_W] = tap_q[i];
   end

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer: per kernel, load weights, clear the engine, stream one frame
// and pack the valid results kernel-major into result memory.
module conv_frame_ctrl
   import conv_ctrl_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ACC_W       = 24,
   parameter int MAX_WIDTH   = 1024,
   parameter int MAX_HEIGHT  = 1024,
   parameter int ADDR_W      = 20,
   parameter int NUM_KERNELS = 8,
   parameter int KIDX_W      = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [15:0]              img_width,
   input  logic [15:0]              img_height,
   input  logic [KIDX_W:0]          n_kern,
   input  logic                     stream_en,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic                     img_rd_en,
   output logic [ADDR_W-1:0]        img_rd_addr,
   input  logic [DATA_W-1:0]        img_rd_data,
   output logic                     w_rd_en,
   output logic [KIDX_W+3:0]        w_rd_addr,
   input  logic [DATA_W-1:0]        w_rd_data,
   output logic                     conv_rst,
   output logic                     conv_in_valid,
   output logic [DATA_W-1:0]        conv_in_pixel,
   output logic [N_TAPS*DATA_W-1:0] conv_kern,
   input  logic                     conv_out_valid,
   input  logic [ACC_W-1:0]         conv_out_pixel,
   output logic                     res_wr_en,
   output logic [ADDR_W-1:0]        res_wr_addr,
   output logic [ACC_W-1:0]         res_wr_data
);

   localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   ctrl_state_t         state_q, state_d;
   logic [KIDX_W-1:0]   kern_q, kern_d;
   logic [KIDX_W:0]     nk_q, nk_d, kern_inc_s;
   logic [ADDR_W-1:0]   wh_q, wh_d, owh_q, owh_d;
   logic [ADDR_W-1:0]   pix_q, pix_d, out_cnt_q, out_cnt_d, res_addr_q, res_addr_d;
   logic [3:0]          tap_q, tap_d, w_tap_s, wtap_q;
   logic                busy_q, busy_d, done_q, done_d, err_q, err_d, conv_rst_q, conv_rst_d;
   logic                w_rd_en_q, w_rd_en_d, img_rd_en_q, img_rd_en_d;
   logic [KIDX_W+3:0]   w_rd_addr_q, w_rd_addr_d;
   logic [ADDR_W-1:0]   img_rd_addr_q, img_rd_addr_d;
   logic                in_valid_q, wload_q, res_acc_s;

   // Results count only while a frame is in flight and only up to the expected number.
   assign res_acc_s = conv_out_valid && ((state_q == ST_STREAM) || (state_q == ST_DRAIN)) &&
                      (out_cnt_q < owh_q);
   assign kern_inc_s = {1'b0, kern_q} + {{KIDX_W{1'b0}}, 1'b1};

   always_comb begin
      state_d       = state_q;
      kern_d        = kern_q;
      nk_d          = nk_q;
      wh_d          = wh_q;
      owh_d         = owh_q;
      tap_d         = tap_q;
      pix_d         = pix_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      err_d         = 1'b0;
      conv_rst_d    = 1'b0;
      w_rd_en_d     = 1'b0;
      w_tap_s       = 4'd0;
      img_rd_en_d   = 1'b0;
      img_rd_addr_d = img_rd_addr_q;
      if (res_acc_s) begin
         out_cnt_d  = out_cnt_q + A_ONE;
         res_addr_d = res_addr_q + A_ONE;
      end else begin
         out_cnt_d  = out_cnt_q;
         res_addr_d = res_addr_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               nk_d  = n_kern;
               wh_d  = ADDR_W'(32'(img_width) * 32'(img_height));
               owh_d = ADDR_W'((32'(img_width) - 32'd2) * (32'(img_height) - 32'd2));
               if (cfg_legal(img_width, img_height, int'(n_kern), MAX_WIDTH, MAX_HEIGHT, NUM_KERNELS)) begin
                  state_d    = ST_LOAD_W;
                  busy_d     = 1'b1;
                  kern_d     = '0;
                  res_addr_d = '0;
                  out_cnt_d  = '0;
                  w_rd_en_d  = 1'b1;
                  w_tap_s    = 4'd0;
                  tap_d      = 4'd1;
               end else begin
                  state_d = ST_FIN;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD_W: begin
            if (tap_q <= LAST_TAP) begin
               w_rd_en_d = 1'b1;
               w_tap_s   = tap_q;
               tap_d     = tap_q + 4'd1;
            end else begin
               tap_d = tap_q;
            end
            // Leave once the word for the last tap has landed in the bank.
            if (wload_q && (wtap_q == LAST_TAP)) begin
               state_d    = ST_CLR;
               conv_rst_d = 1'b1;
            end else begin
               state_d = ST_LOAD_W;
            end
         end
         ST_CLR: begin
            state_d = ST_STREAM;
            if (stream_en) begin
               img_rd_en_d   = 1'b1;
               img_rd_addr_d = '0;
               pix_d         = A_ONE;
            end else begin
               pix_d = '0;
            end
         end
         ST_STREAM: begin
            if (stream_en && (pix_q < wh_q)) begin
               img_rd_en_d   = 1'b1;
               img_rd_addr_d = pix_q;
               pix_d         = pix_q + A_ONE;
               if (pix_q == (wh_q - A_ONE)) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_STREAM;
               end
            end else begin
               state_d = ST_STREAM;
            end
         end
         ST_DRAIN: begin
            if (out_cnt_q == owh_q) begin
               if (kern_inc_s < nk_q) begin
                  kern_d    = kern_inc_s[KIDX_W-1:0];
                  state_d   = ST_LOAD_W;
                  out_cnt_d = '0;
                  w_rd_en_d = 1'b1;
                  w_tap_s   = 4'd0;
                  tap_d     = 4'd1;
               end else begin
                  state_d = ST_FIN;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      if (w_rd_en_d) begin
         w_rd_addr_d = (KIDX_W+4)'(tap_addr(32'(kern_d), w_tap_s));
      end else begin
         w_rd_addr_d = w_rd_addr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         kern_q        <= '0;
         nk_q          <= '0;
         wh_q          <= '0;
         owh_q         <= '0;
         tap_q         <= 4'd0;
         pix_q         <= '0;
         out_cnt_q     <= '0;
         res_addr_q    <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         conv_rst_q    <= 1'b1;
         w_rd_en_q     <= 1'b0;
         w_rd_addr_q   <= '0;
         img_rd_en_q   <= 1'b0;
         img_rd_addr_q <= '0;
         in_valid_q    <= 1'b0;
         wload_q       <= 1'b0;
         wtap_q        <= 4'd0;
      end else begin
         state_q       <= state_d;
         kern_q        <= kern_d;
         nk_q          <= nk_d;
         wh_q          <= wh_d;
         owh_q         <= owh_d;
         tap_q         <= tap_d;
         pix_q         <= pix_d;
         out_cnt_q     <= out_cnt_d;
         res_addr_q    <= res_addr_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_q         <= err_d;
         conv_rst_q    <= conv_rst_d;
         w_rd_en_q     <= w_rd_en_d;
         w_rd_addr_q   <= w_rd_addr_d;
         img_rd_en_q   <= img_rd_en_d;
         img_rd_addr_q <= img_rd_addr_d;
         in_valid_q    <= img_rd_en_q;
         wload_q       <= w_rd_en_q;
         wtap_q        <= w_rd_addr_q[3:0];
      end
   end

   conv_kernel_bank #(.DATA_W(DATA_W)) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wload_q),
      .idx   (wtap_q),
      .wdata (w_rd_data),
      .kern  (conv_kern)
   );

   // The memory's output register is the pixel pipeline stage; mask it when no read returned.
   assign conv_in_pixel = in_valid_q ? img_rd_data : '0;
   assign conv_in_valid = in_valid_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
   assign conv_rst      = conv_rst_q;
   assign w_rd_en       = w_rd_en_q;
   assign w_rd_addr     = w_rd_addr_q;
   assign img_rd_en     = img_rd_en_q;
   assign img_rd_addr   = img_rd_addr_q;
   assign res_wr_en     = res_acc_s;
   assign res_wr_addr   = res_addr_q;
   assign res_wr_data   = res_acc_s ? conv_out_pixel : '0;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Bench for conv_frame_ctrl with behavioural memories, a conv_3x3 engine model
// and a direct-arithmetic reference for the packed result memory.
module tb_conv_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [15:0] img_width = 16'd0, img_height = 16'd0;
   logic [3:0]  n_kern = 4'd0;
   logic        stream_en = 1'b1;
   logic        busy, done, err, img_rd_en, w_rd_en, conv_rst, conv_in_valid, res_wr_en;
   logic [19:0] img_rd_addr, res_wr_addr;
   logic [7:0]  img_rd_data = 8'd0, w_rd_data = 8'd0, conv_in_pixel;
   logic [6:0]  w_rd_addr;
   logic [71:0] conv_kern;
   logic        conv_out_valid;
   logic [23:0] conv_out_pixel, res_wr_data;

   conv_frame_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .img_width(img_width), .img_height(img_height),
      .n_kern(n_kern), .stream_en(stream_en), .busy(busy), .done(done), .err(err),
      .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr), .img_rd_data(img_rd_data),
      .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
      .conv_rst(conv_rst), .conv_in_valid(conv_in_valid), .conv_in_pixel(conv_in_pixel),
      .conv_kern(conv_kern), .conv_out_valid(conv_out_valid), .conv_out_pixel(conv_out_pixel),
      .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data)
   );

   always #5 clk = ~clk;

   logic [7:0] img_mem [0:4095];
   logic [7:0] w_mem [0:127];
   int         res_mem [0:4095];
   int         cur_w = 5;

   // Synchronous-read memories, one cycle of latency.
   always @(posedge clk) begin
      if (img_rd_en) img_rd_data <= img_mem[img_rd_addr[11:0]];
      if (w_rd_en) w_rd_data <= w_mem[w_rd_addr];
   end

   // Engine model: raster-order 3x3 window, results emerge through a 5-stage pipe.
   int e_cnt = 0;
   int e_pix [0:4095];
   bit e_v [0:4];
   int e_d [0:4];
   assign conv_out_valid = e_v[4];
   assign conv_out_pixel = 24'(e_d[4]);

   function automatic int win_sum(int cnt, int w, logic [7:0] cur);
      int r, c, s, idx, p;
      r = cnt / w; c = cnt % w; s = 0;
      for (int t = 0; t < 9; t++) begin
         idx = (r - 2 + t / 3) * w + (c - 2 + t % 3);
         p = (t == 8) ? int'(cur) : e_pix[idx];
         s += int'($signed(conv_kern[t*8 +: 8])) * p;
      end
      return s;
   endfunction

   always @(posedge clk) begin
      if (conv_rst) begin
         e_cnt <= 0;
         for (int i = 0; i < 5; i++) e_v[i] <= 1'b0;
      end else begin
         for (int i = 1; i < 5; i++) begin
            e_v[i] <= e_v[i-1];
            e_d[i] <= e_d[i-1];
         end
         e_v[0] <= 1'b0;
         e_d[0] <= 0;
         if (conv_in_valid) begin
            e_pix[e_cnt] <= int'(conv_in_pixel);
            e_cnt <= e_cnt + 1;
            if ((e_cnt / cur_w >= 2) && (e_cnt % cur_w >= 2)) begin
               e_v[0] <= 1'b1;
               e_d[0] <= win_sum(e_cnt, cur_w, conv_in_pixel);
            end
         end
      end
   end

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int ref_val(int k, int j, int w);
      int ow, r, c, s;
      ow = w - 2; r = j / ow + 1; c = j % ow + 1; s = 0;
      for (int t = 0; t < 9; t++)
         s += int'($signed(w_mem[k*16 + t])) * int'(img_mem[(r - 1 + t / 3) * w + (c - 1 + t % 3)]);
      return s;
   endfunction

   task automatic prep(input int pm, input int wm, input int w);
      for (int a = 0; a < 4096; a++) begin
         img_mem[a] = (pm == 0) ? 8'(a) : 8'($urandom_range(0, 255));
         res_mem[a] = 32'h7fff_ffff;
      end
      for (int a = 0; a < 128; a++) w_mem[a] = 8'd0;
      for (int k = 0; k < 8; k++)
         for (int t = 0; t < 9; t++)
            case (wm)
               0: w_mem[k*16 + t] = (t == 4) ? 8'd1 : 8'd0;
               1: w_mem[k*16 + t] = 8'(k + 1);
               default: w_mem[k*16 + t] = 8'($urandom);
            endcase
      cur_w = w;
   endtask

   int r_done, r_err, r_writes, r_rst, r_img, r_w, r_gap, r_timeout;
   int t_w, t_rst, t_img, t_vld, t_done;

   task automatic run(input int w, input int h, input int nk, input bit thr,
                      input bit busy_start, input int abort_after);
      bit prev_v, dropped, sent;
      r_done = 0; r_err = 0; r_writes = 0; r_rst = 0; r_img = 0; r_w = 0; r_gap = 0;
      r_timeout = 1; t_w = -1; t_rst = -1; t_img = -1; t_vld = -1; t_done = -1;
      prev_v = 1'b0; dropped = 1'b0; sent = 1'b0;
      @(negedge clk);
      img_width = 16'(w); img_height = 16'(h); n_kern = 4'(nk); start = 1'b1;
      for (int c = 1; c <= 5000; c++) begin
         @(negedge clk);
         start = 1'b0;
         stream_en = thr ? ~stream_en : 1'b1;
         if (w_rd_en) begin r_w++; if (t_w < 0) t_w = c; end
         if (conv_rst) begin r_rst++; if (t_rst < 0) t_rst = c; end
         if (img_rd_en) begin r_img++; if (t_img < 0) t_img = c; end
         if (conv_in_valid && t_vld < 0) t_vld = c;
         if (prev_v && !conv_in_valid) dropped = 1'b1;
         if (dropped && conv_in_valid) r_gap = 1;
         prev_v = conv_in_valid;
         if (res_wr_en) begin
            r_writes++;
            if (res_wr_addr < 20'd4096) res_mem[res_wr_addr[11:0]] = int'($signed(res_wr_data));
         end
         if (done) begin
            r_done++;
            if (t_done < 0) begin t_done = c; r_err = int'(err); r_timeout = 0; end
         end
         if (busy_start && !sent && r_img == 3) begin start = 1'b1; sent = 1'b1; end
         if (abort_after > 0 && r_img == abort_after) begin r_timeout = 0; return; end
         if (t_done >= 0 && c >= t_done + 20) return;
      end
   endtask

   task automatic verify(input int w, input int h, input int nk, input bit thr,
                         input bit ex_err, input int ex_wr, input string tag);
      chk({tag, " timeout"}, r_timeout, 0);
      chk({tag, " done_count"}, r_done, 1);
      chk({tag, " err"}, r_err, int'(ex_err));
      chk({tag, " res_writes"}, r_writes, ex_wr);
      if (ex_err) begin
         chk({tag, " done_latency"}, t_done, 1);
         chk({tag, " img_rd_count"}, r_img, 0);
         chk({tag, " w_rd_count"}, r_w, 0);
      end else begin
         chk({tag, " conv_rst_pulses"}, r_rst, nk);
         chk({tag, " w_rd_count"}, r_w, 9 * nk);
         chk({tag, " img_rd_count"}, r_img, w * h * nk);
         for (int k = 0; k < nk; k++)
            for (int j = 0; j < (w - 2) * (h - 2); j++)
               chk($sformatf("%s res[%0d]", tag, k * (w - 2) * (h - 2) + j),
                   res_mem[k * (w - 2) * (h - 2) + j], ref_val(k, j, w));
         if (thr) begin
            chk({tag, " in_valid_gaps"}, r_gap, 1);
         end else begin
            chk({tag, " first_w_rd"}, t_w, 1);
            chk({tag, " first_conv_rst"}, t_rst, 11);
            chk({tag, " first_img_rd"}, t_img, 12);
            chk({tag, " first_in_valid"}, t_vld, 13);
            if (nk == 1) chk({tag, " in_valid_gaps"}, r_gap, 0);
         end
      end
   endtask

   typedef struct {
      int w; int h; int nk; bit thr; int pm; int wm; bit ex_err; int ex_wr;
   } vec_t;

   vec_t vecs [13];
   int   basic_exp [6];

   initial begin
      vecs[0] = '{5, 4, 1, 1'b0, 0, 0, 1'b0, 6};     // basic identity run
      vecs[1] = '{4, 4, 3, 1'b0, 1, 1, 1'b0, 12};    // multi-kernel, all-(k+1)
      vecs[2] = '{5, 4, 1, 1'b1, 0, 0, 1'b0, 6};     // throttled basic
      vecs[3] = '{2, 4, 1, 1'b0, 0, 0, 1'b1, 0};     // width too small
      vecs[4] = '{5, 4, 0, 1'b0, 0, 0, 1'b1, 0};     // zero kernels
      vecs[5] = '{1025, 3, 1, 1'b0, 0, 0, 1'b1, 0};  // width too large
      vecs[6] = '{3, 3, 8, 1'b0, 1, 2, 1'b0, 8};     // min frame, max kernels
      vecs[7] = '{5, 4, 9, 1'b0, 0, 0, 1'b1, 0};     // too many kernels
      for (int i = 8; i < 13; i++) begin
         vecs[i].w = $urandom_range(3, 8);
         vecs[i].h = $urandom_range(3, 6);
         vecs[i].nk = $urandom_range(1, 4);
         vecs[i].thr = 1'($urandom_range(0, 1));
         vecs[i].pm = 1; vecs[i].wm = 2; vecs[i].ex_err = 1'b0;
         vecs[i].ex_wr = vecs[i].nk * (vecs[i].w - 2) * (vecs[i].h - 2);
      end
      basic_exp = '{6, 7, 8, 11, 12, 13};

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset busy", int'(busy), 0);
      chk("reset done_err", int'({done, err}), 0);
      chk("reset rd_en", int'({img_rd_en, w_rd_en, res_wr_en, conv_in_valid}), 0);
      chk("reset conv_rst", int'(conv_rst), 1);
      chk("reset conv_kern_nonzero", int'(conv_kern != 72'd0), 0);
      chk("reset addrs", int'({img_rd_addr, res_wr_addr, 4'(w_rd_addr)} != 44'd0), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         prep(vecs[i].pm, vecs[i].wm, vecs[i].w);
         run(vecs[i].w, vecs[i].h, vecs[i].nk, vecs[i].thr, 1'b0, 0);
         verify(vecs[i].w, vecs[i].h, vecs[i].nk, vecs[i].thr, vecs[i].ex_err,
                vecs[i].ex_wr, $sformatf("vec%0d", i));
         if (i == 0 || i == 2)
            for (int j = 0; j < 6; j++)
               chk($sformatf("vec%0d centre[%0d]", i, j), res_mem[j], basic_exp[j]);
      end

      // A second start while streaming must be ignored.
      prep(0, 0, 5);
      run(5, 4, 1, 1'b0, 1'b1, 0);
      verify(5, 4, 1, 1'b0, 1'b0, 6, "busy_start");

      // Asynchronous reset in the middle of a frame, then a clean rerun.
      prep(1, 2, 6);
      run(6, 5, 2, 1'b0, 1'b0, 5);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst busy", int'(busy), 0);
      chk("midrst img_rd_en", int'(img_rd_en), 0);
      chk("midrst in_valid", int'(conv_in_valid), 0);
      chk("midrst conv_rst", int'(conv_rst), 1);
      chk("midrst conv_kern_nonzero", int'(conv_kern != 72'd0), 0);
      chk("midrst done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run(6, 5, 2, 1'b0, 1'b0, 0);
      verify(6, 5, 2, 1'b0, 1'b0, 24, "after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
